chip_phase_gen: RTL and testbench
=================================

// Module: chip_phase_gen
// PURPOSE
// - Upstream feeder of the CORDIC rotation stage. Turns the O-QPSK chip stream into the MSK-equivalent
//   continuous phase trajectory and drives the rotation stage's 16-bit angle input, in integer degrees [0,359].
// - Each accepted chip ramps the phase by +/-90 deg, linearly over SAMPLES_PER_CHIP clock cycles.
// PARAMETERS
// - SAMPLES_PER_CHIP  9   cycles per chip; must divide 90 (1,2,3,5,6,9,10,15,18,30,45,90)
// - STEP_DEG          90/SAMPLES_PER_CHIP (localparam, not overridable)  per-cycle phase increment
// PORTS
// - clock          in   1   single clock; all logic on rising edge
// - reset          in   1   synchronous, active-high
// - i_chip         in   1   chip value, qualified by i_chip_valid
// - i_chip_valid   in   1   chip available
// - o_chip_ready   out  1   block accepts chip this cycle (transfer = valid & ready)
// - o_angle        out  16  current phase in degrees, always in [0,359]; drives rotation stage angle input
// - o_angle_valid  out  1   o_angle updated this cycle (high during every ramp cycle)
// - o_busy         out  1   state == RAMP
// BEHAVIOUR
// - Reset (sync, active-high): o_angle=0, o_angle_valid=0, o_busy=0, state=IDLE, chip index parity=0,
//   prev_chip=0, sample counter=0. Reset asserted mid-ramp aborts the ramp in that cycle; no partial hold.
// - FSM IDLE: o_chip_ready=1. On transfer -> RAMP, counter=0, direction latched, parity toggles, prev_chip<=i_chip.
// - Direction: up = i_chip ^ prev_chip ^ parity (parity = index of this chip mod 2, first chip after reset = 0).
//   up=1 -> +STEP_DEG per cycle, up=0 -> -STEP_DEG per cycle.
// - FSM RAMP: each cycle o_angle <= wrap(o_angle +/- STEP_DEG), o_angle_valid=1, counter++.
//   o_chip_ready=1 only in the last ramp cycle (counter==SAMPLES_PER_CHIP-1).
//   Last cycle with transfer -> stay RAMP, counter=0, new direction: back-to-back chips give a gapless ramp.
//   Last cycle without transfer -> IDLE; o_angle holds, o_angle_valid=0 from next cycle.
// - Latency: chip transferred at edge T -> first stepped angle visible after edge T+1; after SAMPLES_PER_CHIP
//   ramp cycles the net phase change is exactly +/-90 deg (mod 360).
// - Wrap rules (no modulo operator): up: sum>=360 -> sum-360; down: angle<STEP_DEG -> angle+360-STEP_DEG.
//   o_angle never leaves [0,359]; the upper 7 bits are zero at all times.
// - i_chip / i_chip_valid ignored while o_chip_ready=0 (no buffering, no skid register).
// CONFIGURATION
// - `define CHIP_PHASE_UNDERRUN_EN: adds output o_underrun_cnt [7:0]. Incremented on each RAMP->IDLE exit
//   (chip boundary passed with no chip available), saturates at 255, cleared only by reset.
// - Without the macro the port and counter do not exist; FSM behaviour is identical.
// STRUCTURE
// - Package zigbee_cordic_pkg: ANGLE_W=16, DEG_360=16'd360, DEG_90=16'd90, typedef enum logic {IDLE,RAMP}
//   phase_state_t; shared with the rotation stage so both agree on angle width and units.
// - Sub-module phase_wrap (combinational): in angle, step, up -> wrapped angle; reused by downstream stages.
// - Top: FSM, sample counter ($clog2(SAMPLES_PER_CHIP) bits), prev_chip/parity flops, angle register.
// TESTING (SAMPLES_PER_CHIP=9, STEP_DEG=10)
// - Reset held 3 cycles -> o_angle=0, o_angle_valid=0, o_chip_ready=1, o_busy=0.
// - Single chip 1 after reset (up=1^0^0=1) -> o_angle 10,20,...,90 over 9 cycles, then holds 90, valid drops.
// - Chips 1,1 back-to-back (second: 1^1^1=1, up) -> 10..180 in 18 consecutive valid cycles, no gap, ready
//   high only in cycles 9 and 18.
// - Wrap: from 270 send up-chip -> ...,350,0,...,0 after 9 cycles ends at 0; from 0 down-chip -> 350,...,270.
// - Reset asserted at ramp cycle 4 -> next edge o_angle=0, IDLE, parity/prev_chip cleared; next chip ramps from 0.
// - CHIP_PHASE_UNDERRUN_EN: 3 isolated chips with idle gaps -> o_underrun_cnt=3; 300 isolated chips -> 255.

Source files
------------

// File: rtl/zigbee_cordic_pkg.sv
// Shared angle width, degree constants and phase FSM state type for the
// chip phase generator and the downstream CORDIC rotation stage.
package zigbee_cordic_pkg;

   localparam int ANGLE_W = 16;
   localparam logic [ANGLE_W-1:0] DEG_360 = 16'd360;
   localparam logic [ANGLE_W-1:0] DEG_90  = 16'd90;

   typedef enum logic {
      IDLE,
      RAMP
   } phase_state_t;

endpackage

// File: rtl/phase_wrap.sv
// Combinational one-step phase advance in integer degrees, wrapped into [0,359]
// without a modulo operator. Assumes angle_i is already in range and step_i <= 360.
module phase_wrap
   import zigbee_cordic_pkg::*;
(
   input  logic [ANGLE_W-1:0] angle_i,
   input  logic [ANGLE_W-1:0] step_i,
   input  logic               up_i,
   output logic [ANGLE_W-1:0] angle_o
);

   localparam logic [ANGLE_W:0] DEG_360_W = {1'b0, DEG_360};

   logic [ANGLE_W:0] angle_w;
   logic [ANGLE_W:0] step_w;
   logic [ANGLE_W:0] sum_w;
   logic [ANGLE_W:0] res_w;

   assign angle_w = {1'b0, angle_i};
   assign step_w  = {1'b0, step_i};
   assign sum_w   = angle_w + step_w;

   always_comb begin
      res_w = angle_w;
      if (up_i) begin
         res_w = (sum_w >= DEG_360_W) ? (sum_w - DEG_360_W) : sum_w;
      end else begin
         // Adding 360 before subtracting keeps the down path free of underflow.
         res_w = (angle_w < step_w) ? (angle_w + DEG_360_W - step_w) : (angle_w - step_w);
      end
   end

   assign angle_o = res_w[ANGLE_W-1:0];

endmodule

// File: rtl/chip_phase_gen.sv
// O-QPSK chip stream to MSK phase trajectory: each accepted chip ramps the angle by
// +/-90 deg over SAMPLES_PER_CHIP cycles. Optional macro CHIP_PHASE_UNDERRUN_EN adds o_underrun_cnt.
module chip_phase_gen
   import zigbee_cordic_pkg::*;
#(
   parameter int SAMPLES_PER_CHIP = 9
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               i_chip,
   input  logic               i_chip_valid,
   output logic               o_chip_ready,
   output logic [ANGLE_W-1:0] o_angle,
   output logic               o_angle_valid,
   output logic               o_busy
`ifdef CHIP_PHASE_UNDERRUN_EN
   ,
   output logic [7:0]         o_underrun_cnt
`endif
);

   localparam int STEP_DEG = 90 / SAMPLES_PER_CHIP;
   localparam int CNT_W    = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SAMPLES_PER_CHIP - 1);
   localparam logic [ANGLE_W-1:0] STEP_W   = ANGLE_W'(STEP_DEG);

   phase_state_t       state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               up_q, up_d;
   logic               parity_q, parity_d;
   logic               prev_q, prev_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic               valid_q, valid_d;
   logic [ANGLE_W-1:0] angle_step;
   logic               last_cycle;
   logic               ready;
   logic               xfer;

   phase_wrap u_wrap (
      .angle_i (angle_q),
      .step_i  (STEP_W),
      .up_i    (up_q),
      .angle_o (angle_step)
   );

   assign last_cycle = (cnt_q == CNT_LAST);
   assign xfer       = i_chip_valid & ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      up_d     = up_q;
      parity_d = parity_q;
      prev_d   = prev_q;
      angle_d  = angle_q;
      valid_d  = 1'b0;
      ready    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
         end
         RAMP: begin
            ready   = last_cycle;
            angle_d = angle_step;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (last_cycle && !i_chip_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A chip taken in IDLE or in the last ramp cycle starts a fresh ramp with no gap.
      if (xfer) begin
         state_d  = RAMP;
         cnt_d    = '0;
         up_d     = i_chip ^ prev_q ^ parity_q;
         parity_d = ~parity_q;
         prev_d   = i_chip;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         up_q     <= 1'b0;
         parity_q <= 1'b0;
         prev_q   <= 1'b0;
         angle_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         up_q     <= up_d;
         parity_q <= parity_d;
         prev_q   <= prev_d;
         angle_q  <= angle_d;
         valid_q  <= valid_d;
      end
   end

   assign o_chip_ready  = ready;
   assign o_angle       = angle_q;
   assign o_angle_valid = valid_q;
   assign o_busy        = (state_q == RAMP);

`ifdef CHIP_PHASE_UNDERRUN_EN
   logic [7:0] underrun_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         underrun_q <= '0;
      end else if ((state_q == RAMP) && last_cycle && !i_chip_valid && (underrun_q != 8'hFF)) begin
         underrun_q <= underrun_q + 8'd1;
      end
   end

   assign o_underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_chip_phase_gen.sv
// Directed plus randomized bench for chip_phase_gen against a degree-arithmetic phase model.
module tb_chip_phase_gen;

   localparam int SPC  = 9;
   localparam int STEP = 90 / SPC;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_chip;
   logic        i_chip_valid;
   logic        o_chip_ready;
   logic [15:0] o_angle;
   logic        o_angle_valid;
   logic        o_busy;
`ifdef CHIP_PHASE_UNDERRUN_EN
   logic [7:0]  o_underrun_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state: angle in degrees, position within the current chip.
   int m_angle, m_k, m_idx, m_und;
   bit m_busy, m_valid, m_up, m_prev;

   chip_phase_gen #(.SAMPLES_PER_CHIP(SPC)) dut (
      .clock         (clock),
      .reset         (reset),
      .i_chip        (i_chip),
      .i_chip_valid  (i_chip_valid),
      .o_chip_ready  (o_chip_ready),
      .o_angle       (o_angle),
      .o_angle_valid (o_angle_valid),
      .o_busy        (o_busy)
`ifdef CHIP_PHASE_UNDERRUN_EN
      ,
      .o_underrun_cnt(o_underrun_cnt)
`endif
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_angle = 0; m_k = 0; m_idx = 0; m_und = 0;
      m_busy = 0; m_valid = 0; m_up = 0; m_prev = 0;
   endtask

   task automatic model_edge(input bit r, input bit xfer, input bit c);
      if (r) begin
         model_reset();
      end else begin
         if (m_busy) begin
            m_angle = (m_angle + (m_up ? STEP : 360 - STEP)) % 360;
            m_valid = 1;
            m_k++;
         end else begin
            m_valid = 0;
         end
         if (xfer) begin
            m_up   = c ^ m_prev ^ m_idx[0];
            m_idx++;
            m_prev = c;
            m_busy = 1;
            m_k    = 0;
         end else if (m_busy && m_k == SPC) begin
            m_busy = 0;
            if (m_und < 255) m_und++;
         end
      end
   endtask

   task automatic cycle(input bit r, input bit v, input bit c, output bit acc);
      bit exp_ready;
      @(negedge clock);
      reset = r; i_chip_valid = v; i_chip = c;
      #1;
      exp_ready = !m_busy || (m_k == SPC - 1);
      chk("ready", o_chip_ready, exp_ready);
      chk("busy", o_busy, m_busy);
      acc = v && exp_ready && !r;
      @(posedge clock);
      model_edge(r, v && exp_ready, c);
      #1;
      chk("angle", o_angle, m_angle);
      chk("angle_valid", o_angle_valid, m_valid);
`ifdef CHIP_PHASE_UNDERRUN_EN
      chk("underrun", o_underrun_cnt, m_und);
`endif
      $display("t=%0t rst=%0b v=%0b chip=%0b acc=%0b angle=%0d valid=%0b busy=%0b",
               $time, r, v, c, acc, o_angle, o_angle_valid, o_busy);
   endtask

   task automatic send(input bit c);
      bit acc = 0;
      for (int i = 0; i < 2 * SPC + 2 && !acc; i++) cycle(0, 1, c, acc);
      checks++;
      assert (acc === 1'b1) else begin
         errors++;
         $error("FAIL send_timeout observed %0b expected 1", acc);
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(0, 0, 0, acc);
   endtask

   initial begin
      bit acc;
      reset = 1'b1; i_chip = 1'b0; i_chip_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      model_reset();
      chk("rst_angle", o_angle, 0);
      chk("rst_valid", o_angle_valid, 0);
      chk("rst_ready", o_chip_ready, 1);
      chk("rst_busy", o_busy, 0);

      // Single up chip: 10..90 then hold.
      send(1);
      idle(12);
      chk("single_end", o_angle, 90);
      chk("single_valid", o_angle_valid, 0);

      // Two back-to-back up chips: gapless 10..180.
      cycle(1, 0, 0, acc);
      send(1);
      send(1);
      idle(12);
      chk("b2b_end", o_angle, 180);

      // Up to 270, up-chip wraps to 0, then down-chip wraps to 270.
      cycle(1, 0, 0, acc);
      send(1); send(1); send(0);
      idle(12);
      chk("to_270", o_angle, 270);
      send(0);
      idle(12);
      chk("wrap_up", o_angle, 0);
      send(0);
      idle(12);
      chk("wrap_down", o_angle, 270);

      // Reset during ramp cycle 4 aborts, then parity/prev restart from zero.
      cycle(1, 0, 0, acc);
      send(1);
      idle(3);
      cycle(1, 0, 0, acc);
      chk("abort_angle", o_angle, 0);
      chk("abort_busy", o_busy, 0);
      send(1);
      idle(12);
      chk("after_abort", o_angle, 90);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
               $urandom_range(0, 1), acc);
      end

`ifdef CHIP_PHASE_UNDERRUN_EN
      cycle(1, 0, 0, acc);
      for (int i = 0; i < 3; i++) begin
         send($urandom_range(0, 1));
         idle(12);
      end
      chk("underrun_3", o_underrun_cnt, 3);
      for (int i = 0; i < 300; i++) begin
         send($urandom_range(0, 1));
         idle(10);
      end
      chk("underrun_sat", o_underrun_cnt, 255);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
